// File: rtl/colormem_wr_arb_pkg.sv
// rtl/colormem_wr_arb_pkg.sv - shared types for the colour BRAM write arbiter
package colormem_wr_arb_pkg;

   typedef logic [15:0] word_t;

   localparam int COLOR_AW = 8;

   typedef enum logic [1:0] {
      FILL_IDLE,
      FILL_RUN,
      FILL_DONE
   } fill_state_t;

endpackage

// File: rtl/colormem_wr_arb_if.sv
// rtl/colormem_wr_arb_if.sv - requester and BRAM write-port bundle for the colour arbiter
interface colormem_wr_arb_if
   import colormem_wr_arb_pkg::*;
#(
   parameter int AWIDTH = COLOR_AW
);
   logic              cop_wr_i;
   logic [AWIDTH-1:0] cop_addr_i;
   word_t             cop_data_i;

   logic              cpu_req_i;
   logic [AWIDTH-1:0] cpu_addr_i;
   word_t             cpu_data_i;
   logic              cpu_ack_o;

   logic              fill_start_i;
   logic [AWIDTH-1:0] fill_base_i;
   logic [AWIDTH:0]   fill_count_i;
   word_t             fill_data_i;
   logic              fill_busy_o;
   logic              fill_done_o;

   logic              mem_wr_en_o;
   logic [AWIDTH-1:0] mem_wr_addr_o;
   word_t             mem_wr_data_o;

   modport master (
      output cop_wr_i, cop_addr_i, cop_data_i,
      output cpu_req_i, cpu_addr_i, cpu_data_i,
      input  cpu_ack_o,
      output fill_start_i, fill_base_i, fill_count_i, fill_data_i,
      input  fill_busy_o, fill_done_o,
      input  mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o
   );

   modport slave (
      input  cop_wr_i, cop_addr_i, cop_data_i,
      input  cpu_req_i, cpu_addr_i, cpu_data_i,
      output cpu_ack_o,
      input  fill_start_i, fill_base_i, fill_count_i, fill_data_i,
      output fill_busy_o, fill_done_o,
      output mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o
   );
endinterface

// File: rtl/colormem_wr_arb_fill.sv
// rtl/colormem_wr_arb_fill.sv - palette fill sequencer issuing one write per granted cycle
module colormem_fill
   import colormem_wr_arb_pkg::*;
#(
   parameter int AWIDTH = COLOR_AW
) (
   input  logic              clk,
   input  logic              reset_ni,
   input  logic              start_i,
   input  logic [AWIDTH-1:0] base_i,
   input  logic [AWIDTH:0]   count_i,
   input  word_t             data_i,
   input  logic              fill_gnt,
   output logic              fill_req,
   output logic [AWIDTH-1:0] fill_addr,
   output word_t             fill_data,
   output logic              busy_o,
   output logic              done_o
);

   fill_state_t       state_q, state_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [AWIDTH:0]   remain_q, remain_d;
   word_t             data_q, data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      data_d   = data_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         FILL_IDLE: begin
            if (start_i) begin
               if (count_i == '0) begin
                  state_d = FILL_DONE;
               end else begin
                  state_d  = FILL_RUN;
                  addr_d   = base_i;
                  remain_d = count_i;
                  data_d   = data_i;
                  busy_d   = 1'b1;
               end
            end
         end
         FILL_RUN: begin
            if (fill_gnt) begin
               addr_d   = addr_q + AWIDTH'(1);
               remain_d = remain_q - (AWIDTH + 1)'(1);
               if (remain_q == (AWIDTH + 1)'(1)) begin
                  state_d = FILL_DONE;
               end
            end
         end
         FILL_DONE: begin
            // busy stays up through the cycle the last write is on the port
            state_d = FILL_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = FILL_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= FILL_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign fill_req  = (state_q == FILL_RUN);
   assign fill_addr = addr_q;
   assign fill_data = data_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule

// File: rtl/colormem_wr_arb.sv
// rtl/colormem_wr_arb.sv - copper > CPU > fill priority grant onto the colour BRAM write port
module colormem_wr_arb
   import colormem_wr_arb_pkg::*;
#(
   parameter int AWIDTH = COLOR_AW
) (
   input  logic               clk,
   input  logic               reset_ni,
   colormem_wr_arb_if.slave   bus
);

   logic              fill_req;
   logic              fill_gnt;
   logic [AWIDTH-1:0] fill_addr;
   word_t             fill_data;
   logic              cpu_gnt;

   logic              wr_en_q, wr_en_d;
   logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
   word_t             wr_data_q, wr_data_d;
   logic              cpu_ack_q, cpu_ack_d;

   colormem_fill #(.AWIDTH(AWIDTH)) u_fill (
      .clk       (clk),
      .reset_ni  (reset_ni),
      .start_i   (bus.fill_start_i),
      .base_i    (bus.fill_base_i),
      .count_i   (bus.fill_count_i),
      .data_i    (bus.fill_data_i),
      .fill_gnt  (fill_gnt),
      .fill_req  (fill_req),
      .fill_addr (fill_addr),
      .fill_data (fill_data),
      .busy_o    (bus.fill_busy_o),
      .done_o    (bus.fill_done_o)
   );

   // the request is still high during the ack cycle, so it must be masked to avoid a double write
   assign cpu_gnt  = bus.cpu_req_i && !bus.cop_wr_i && !cpu_ack_q;
   assign fill_gnt = fill_req && !bus.cop_wr_i && !cpu_gnt;

   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      cpu_ack_d = 1'b0;
      if (bus.cop_wr_i) begin
         wr_en_d   = 1'b1;
         wr_addr_d = bus.cop_addr_i;
         wr_data_d = bus.cop_data_i;
      end else if (cpu_gnt) begin
         wr_en_d   = 1'b1;
         wr_addr_d = bus.cpu_addr_i;
         wr_data_d = bus.cpu_data_i;
         cpu_ack_d = 1'b1;
      end else if (fill_gnt) begin
         wr_en_d   = 1'b1;
         wr_addr_d = fill_addr;
         wr_data_d = fill_data;
      end
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         cpu_ack_q <= 1'b0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         cpu_ack_q <= cpu_ack_d;
      end
   end

   assign bus.mem_wr_en_o   = wr_en_q;
   assign bus.mem_wr_addr_o = wr_addr_q;
   assign bus.mem_wr_data_o = wr_data_q;
   assign bus.cpu_ack_o     = cpu_ack_q;

endmodule

// File: tb/tb_colormem_wr_arb.sv
// tb/tb_colormem_wr_arb.sv - directed self-checking bench for colormem_wr_arb
module tb_colormem_wr_arb;
   import colormem_wr_arb_pkg::*;

   logic clk = 1'b0;
   logic reset_ni = 1'b0;

   colormem_wr_arb_if #(.AWIDTH(8)) bus ();

   colormem_wr_arb #(.AWIDTH(8)) dut (
      .clk      (clk),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int    tests = 0;
   int    fails = 0;
   word_t mem [256];
   logic [7:0] flog [$];
   word_t fill_pat = 16'h0000;
   int    done_cnt = 0;

   always @(posedge clk) begin
      if (bus.mem_wr_en_o) begin
         mem[bus.mem_wr_addr_o] <= bus.mem_wr_data_o;
         if (bus.mem_wr_data_o == fill_pat) flog.push_back(bus.mem_wr_addr_o);
      end
      if (bus.fill_done_o) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fb, d0, wr, bad, done_tick;
      logic [7:0] a;

      bus.cop_wr_i = 0; bus.cop_addr_i = 0; bus.cop_data_i = 0;
      bus.cpu_req_i = 0; bus.cpu_addr_i = 0; bus.cpu_data_i = 0;
      bus.fill_start_i = 0; bus.fill_base_i = 0; bus.fill_count_i = 0; bus.fill_data_i = 0;

      // reset state
      #22;
      chk("rst_en", bus.mem_wr_en_o, 0);
      chk("rst_ack", bus.cpu_ack_o, 0);
      chk("rst_busy", bus.fill_busy_o, 0);
      chk("rst_done", bus.fill_done_o, 0);
      reset_ni = 1'b1;
      tick();
      chk("idle_en", bus.mem_wr_en_o, 0);

      // reset mid-fill aborts asynchronously
      fill_pat = 16'h7777;
      d0 = done_cnt;
      bus.fill_start_i = 1; bus.fill_base_i = 8'h10; bus.fill_count_i = 9'd10; bus.fill_data_i = 16'h7777;
      tick();
      bus.fill_start_i = 0;
      tick();
      tick();
      chk("mid_busy", bus.fill_busy_o, 1);
      chk("mid_en", bus.mem_wr_en_o, 1);
      #2 reset_ni = 1'b0;
      #1;
      chk("async_en", bus.mem_wr_en_o, 0);
      chk("async_busy", bus.fill_busy_o, 0);
      chk("async_addr", bus.mem_wr_addr_o, 0);
      chk("async_data", bus.mem_wr_data_o, 0);
      @(posedge clk);
      #3 reset_ni = 1'b1;
      wr = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus.mem_wr_en_o) wr++;
      end
      chk("post_rst_writes", wr, 0);
      chk("post_rst_busy", bus.fill_busy_o, 0);
      chk("post_rst_no_done", done_cnt - d0, 0);

      // CPU alone, request held one extra cycle
      bus.cpu_req_i = 1; bus.cpu_addr_i = 8'h12; bus.cpu_data_i = 16'h0F0F;
      tick();
      chk("cpu_en", bus.mem_wr_en_o, 1);
      chk("cpu_addr", bus.mem_wr_addr_o, 32'h12);
      chk("cpu_data", bus.mem_wr_data_o, 32'h0F0F);
      chk("cpu_ack", bus.cpu_ack_o, 1);
      tick();
      chk("cpu_hold_en", bus.mem_wr_en_o, 0);
      chk("cpu_hold_ack", bus.cpu_ack_o, 0);
      bus.cpu_req_i = 0;
      tick();
      chk("cpu_after_en", bus.mem_wr_en_o, 0);

      // copper/CPU collision on the same address
      bus.cop_wr_i = 1; bus.cop_addr_i = 8'h05; bus.cop_data_i = 16'hAAAA;
      bus.cpu_req_i = 1; bus.cpu_addr_i = 8'h05; bus.cpu_data_i = 16'h5555;
      tick();
      bus.cop_wr_i = 0;
      chk("col1_en", bus.mem_wr_en_o, 1);
      chk("col1_data", bus.mem_wr_data_o, 32'hAAAA);
      chk("col1_ack", bus.cpu_ack_o, 0);
      tick();
      bus.cpu_req_i = 0;
      chk("col2_en", bus.mem_wr_en_o, 1);
      chk("col2_addr", bus.mem_wr_addr_o, 32'h05);
      chk("col2_data", bus.mem_wr_data_o, 32'h5555);
      chk("col2_ack", bus.cpu_ack_o, 1);
      tick();
      chk("col_mem5", mem[5], 32'h5555);

      // wrapping fill
      fill_pat = 16'h1234;
      bus.fill_start_i = 1; bus.fill_base_i = 8'hFE; bus.fill_count_i = 9'd4; bus.fill_data_i = 16'h1234;
      tick();
      bus.fill_start_i = 0;
      chk("wrap_busy0", bus.fill_busy_o, 1);
      chk("wrap_en0", bus.mem_wr_en_o, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         a = 8'hFE + 8'(i);
         chk("wrap_en", bus.mem_wr_en_o, 1);
         chk("wrap_addr", bus.mem_wr_addr_o, {24'h0, a});
         chk("wrap_data", bus.mem_wr_data_o, 32'h1234);
         chk("wrap_busy", bus.fill_busy_o, 1);
      end
      tick();
      chk("wrap_end_busy", bus.fill_busy_o, 0);
      chk("wrap_done", bus.fill_done_o, 1);
      chk("wrap_end_en", bus.mem_wr_en_o, 0);
      tick();
      chk("wrap_done_pulse", bus.fill_done_o, 0);

      // fill interleaved with a CPU write and two copper writes
      fill_pat = 16'hBEEF;
      fb = flog.size();
      bus.fill_start_i = 1; bus.fill_base_i = 8'h40; bus.fill_count_i = 9'd6; bus.fill_data_i = 16'hBEEF;
      tick();
      bus.fill_start_i = 0;
      tick();
      chk("il_first", bus.mem_wr_addr_o, 32'h40);
      bus.cpu_req_i = 1; bus.cpu_addr_i = 8'h90; bus.cpu_data_i = 16'h1111;
      tick();
      chk("il_cpu", bus.mem_wr_data_o, 32'h1111);
      chk("il_cpu_ack", bus.cpu_ack_o, 1);
      bus.cpu_req_i = 0;
      bus.cop_wr_i = 1; bus.cop_addr_i = 8'h91; bus.cop_data_i = 16'h2222;
      tick();
      chk("il_cop1", bus.mem_wr_addr_o, 32'h91);
      bus.cop_addr_i = 8'h92; bus.cop_data_i = 16'h3333;
      tick();
      bus.cop_wr_i = 0;
      chk("il_cop2", bus.mem_wr_addr_o, 32'h92);
      done_tick = -1;
      for (int k = 5; k <= 40; k++) begin
         tick();
         if (bus.fill_done_o) begin
            done_tick = k;
            break;
         end
      end
      chk("il_done_tick", done_tick, 10);
      tick();
      chk("il_count", flog.size() - fb, 6);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (fb + i >= flog.size() || flog[fb + i] != 8'h40 + 8'(i)) bad++;
      end
      chk("il_order", bad, 0);

      // count = 0
      fb = flog.size();
      d0 = done_cnt;
      bus.fill_start_i = 1; bus.fill_base_i = 8'h33; bus.fill_count_i = 9'd0; bus.fill_data_i = 16'hBEEF;
      tick();
      bus.fill_start_i = 0;
      chk("c0_busy", bus.fill_busy_o, 0);
      chk("c0_en", bus.mem_wr_en_o, 0);
      tick();
      chk("c0_done", bus.fill_done_o, 1);
      chk("c0_en2", bus.mem_wr_en_o, 0);
      tick();
      chk("c0_done_pulse", bus.fill_done_o, 0);
      chk("c0_writes", flog.size() - fb, 0);
      chk("c0_done_cnt", done_cnt - d0, 1);

      // count = 256, with a start pulse while busy
      fill_pat = 16'hC0DE;
      fb = flog.size();
      d0 = done_cnt;
      bus.fill_start_i = 1; bus.fill_base_i = 8'h80; bus.fill_count_i = 9'd256; bus.fill_data_i = 16'hC0DE;
      tick();
      bus.fill_start_i = 0;
      done_tick = -1;
      for (int k = 1; k <= 400; k++) begin
         if (k == 10) begin
            bus.fill_start_i = 1; bus.fill_base_i = 8'h00; bus.fill_count_i = 9'd5;
         end else begin
            bus.fill_start_i = 0;
         end
         tick();
         if (bus.fill_done_o) begin
            done_tick = k;
            break;
         end
      end
      bus.fill_start_i = 0;
      chk("full_done_tick", done_tick, 257);
      tick();
      tick();
      tick();
      chk("full_done_cnt", done_cnt - d0, 1);
      chk("full_count", flog.size() - fb, 256);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (fb + i >= flog.size() || flog[fb + i] != 8'h80 + 8'(i)) bad++;
      end
      chk("full_order", bad, 0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== 16'hC0DE) bad++;
      chk("full_mem", bad, 0);
      chk("full_busy_end", bus.fill_busy_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
